// File: rtl/rf_alu_exec.sv
// Register-file + ALU execute unit: one op per cycle, iterative 1-bit/cycle shifter,
// flag-only compare and a one-cycle completion strobe.
module rf_alu_exec #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [REGBITS-1:0] rdest,
  input  logic [REGBITS-1:0] rsrc,
  input  logic [WIDTH-1:0]   imm,
  input  logic               use_imm,
  output logic               out_valid,
  output logic               out_we,
  output logic [REGBITS-1:0] out_rdest,
  output logic [WIDTH-1:0]   out_data,
  output logic [7:0]         PSR,
  output logic               busy
);

  localparam int NREG = 1 << REGBITS;
  localparam logic [SHAMT_W-1:0] KMAX = SHAMT_W'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MOV  = 4'd5;
  localparam logic [3:0] OP_CMP  = 4'd6;
  localparam logic [3:0] OP_LSH  = 4'd7;
  localparam logic [3:0] OP_LSHR = 4'd8;
  localparam logic [3:0] OP_ASHR = 4'd9;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Bit WIDTH of the extended difference is the borrow (unsigned a < b).
  function automatic logic [WIDTH:0] sub_ext(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // One shift step; returns {bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift_step(input logic [3:0] kind, input logic [WIDTH-1:0] v);
    case (kind)
      OP_LSH:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_LSHR: return {v[0], 1'b0, v[WIDTH-1:1]};
      default: return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  state_t             state;
  logic [WIDTH-1:0]   regs [NREG];
  logic               c_f, l_f, f_f, z_f, n_f;

  logic [WIDTH-1:0]   sh_val_p1;
  logic [SHAMT_W-1:0] sh_cnt_p1;
  logic [3:0]         sh_op_p1;
  logic [REGBITS-1:0] sh_rd_p1;

  logic                      xfer_p0;
  logic [WIDTH-1:0]          a_p0, b_p0, res_p0;
  logic signed [WIDTH-1:0]   a_s_p0, b_s_p0;
  logic [WIDTH:0]            sum_p0, dif_p0, step_p1;
  logic [SHAMT_W-1:0]        k_p0, k_clamp_p0;
  logic                      is_shift_p0, we_p0;
  logic                      nc_p0, nl_p0, nf_p0, nz_p0, nn_p0;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign PSR      = {n_f, z_f, f_f, 2'b00, l_f, 1'b0, c_f};

  // Stage p0: operand fetch and single-cycle ALU evaluation at the transfer cycle
  assign xfer_p0     = in_valid & in_ready;
  assign a_p0        = regs[rdest];
  assign b_p0        = use_imm ? imm : regs[rsrc];
  assign a_s_p0      = a_p0;
  assign b_s_p0      = b_p0;
  assign sum_p0      = add_ext(a_p0, b_p0);
  assign dif_p0      = sub_ext(a_p0, b_p0);
  assign k_p0        = b_p0[SHAMT_W-1:0];
  assign k_clamp_p0  = (k_p0 > KMAX) ? KMAX : k_p0;
  assign is_shift_p0 = (op == OP_LSH) || (op == OP_LSHR) || (op == OP_ASHR);
  assign step_p1     = shift_step(sh_op_p1, sh_val_p1);

  always_comb begin
    res_p0 = '0;
    we_p0  = 1'b0;
    nc_p0  = c_f;
    nl_p0  = l_f;
    nf_p0  = f_f;
    nz_p0  = z_f;
    nn_p0  = n_f;
    case (op)
      OP_ADD: begin
        res_p0 = sum_p0[WIDTH-1:0];
        we_p0  = 1'b1;
        nc_p0  = sum_p0[WIDTH];
        nf_p0  = add_ovf(a_p0, b_p0, res_p0);
        nz_p0  = (res_p0 == '0);
        nn_p0  = res_p0[WIDTH-1];
      end
      OP_SUB: begin
        res_p0 = dif_p0[WIDTH-1:0];
        we_p0  = 1'b1;
        nc_p0  = dif_p0[WIDTH];
        nf_p0  = sub_ovf(a_p0, b_p0, res_p0);
        nz_p0  = (res_p0 == '0);
        nn_p0  = res_p0[WIDTH-1];
      end
      OP_AND, OP_OR, OP_XOR, OP_MOV: begin
        case (op)
          OP_AND:  res_p0 = a_p0 & b_p0;
          OP_OR:   res_p0 = a_p0 | b_p0;
          OP_XOR:  res_p0 = a_p0 ^ b_p0;
          default: res_p0 = b_p0;
        endcase
        we_p0 = 1'b1;
        nz_p0 = (res_p0 == '0);
        nn_p0 = res_p0[WIDTH-1];
      end
      OP_CMP: begin
        res_p0 = dif_p0[WIDTH-1:0];
        nc_p0  = dif_p0[WIDTH];
        nf_p0  = sub_ovf(a_p0, b_p0, res_p0);
        nz_p0  = (a_p0 == b_p0);
        nn_p0  = (a_s_p0 < b_s_p0);
        nl_p0  = (a_p0 < b_p0);
      end
      // Zero-distance shifts complete here; longer shifts are handled by the SHIFT state.
      OP_LSH, OP_LSHR, OP_ASHR: begin
        res_p0 = a_p0;
        we_p0  = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage p1: register file, flags, shifter iteration and completion outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      c_f       <= 1'b0;
      l_f       <= 1'b0;
      f_f       <= 1'b0;
      z_f       <= 1'b0;
      n_f       <= 1'b0;
      sh_val_p1 <= '0;
      sh_cnt_p1 <= '0;
      sh_op_p1  <= '0;
      sh_rd_p1  <= '0;
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      out_rdest <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer_p0) begin
            if (is_shift_p0 && (k_p0 != '0)) begin
              state     <= SHIFT;
              sh_val_p1 <= a_p0;
              sh_cnt_p1 <= k_clamp_p0;
              sh_op_p1  <= op;
              sh_rd_p1  <= rdest;
            end else begin
              if (we_p0) regs[rdest] <= res_p0;
              c_f       <= nc_p0;
              l_f       <= nl_p0;
              f_f       <= nf_p0;
              z_f       <= nz_p0;
              n_f       <= nn_p0;
              out_valid <= 1'b1;
              out_we    <= we_p0;
              out_rdest <= rdest;
              out_data  <= res_p0;
            end
          end
        end
        SHIFT: begin
          sh_val_p1 <= step_p1[WIDTH-1:0];
          sh_cnt_p1 <= sh_cnt_p1 - 1'b1;
          if (sh_cnt_p1 == SHAMT_W'(1)) begin
            state          <= IDLE;
            regs[sh_rd_p1] <= step_p1[WIDTH-1:0];
            c_f            <= step_p1[WIDTH];
            z_f            <= (step_p1[WIDTH-1:0] == '0);
            n_f            <= step_p1[WIDTH-1];
            out_valid      <= 1'b1;
            out_we         <= 1'b1;
            out_rdest      <= sh_rd_p1;
            out_data       <= step_p1[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
